// File: rtl/hc595_pkg.sv
// hc595_pkg: shared constants and segment decode for the 74HC595 link receiver.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}.
package hc595_pkg;

  localparam int FRAME_BITS_DEF = 16;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] SEG_CODE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83,
    8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct packed {
    logic       known;
    logic       blank;
    logic [3:0] nibble;
  } seg_dec_t;

  // The dp bit is forced off before lookup; blank decodes as nibble 0.
  function automatic seg_dec_t hc595_decode(input logic [7:0] seg);
    seg_dec_t   r;
    logic [7:0] s;
    s = seg | 8'h80;
    r = '0;
    if (s == SEG_BLANK) begin
      r.known = 1'b1;
      r.blank = 1'b1;
    end
    for (int i = 0; i < 16; i++) begin
      if (s == SEG_CODE[i]) begin
        r.known  = 1'b1;
        r.nibble = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hc595_frame_rx_link_sync.sv
// link_sync: multi-flop synchroniser with a registered rising-edge pulse.
// The pulse lands one cycle after the synchronised level first goes high.
module link_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              hist;

  // Synchronise, keep one history flop, register the rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      hist   <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      hist   <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~hist;
    end
  end

endmodule

// File: rtl/hc595_frame_rx.sv
// hc595_frame_rx: over-sampled 74HC595 link receiver with frame checks
// and a per-digit decoded display buffer.
module hc595_frame_rx
  import hc595_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int DIGITS      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RCLK,
  input  logic                  SRCLK,
  input  logic                  DIO,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  output logic [4*DIGITS-1:0]   disp_nibbles,
  output logic [DIGITS-1:0]     blank_mask,
  output logic [DIGITS-1:0]     dp_mask,
  output logic                  len_err,
  output logic                  code_err,
  output logic                  sel_err
);

  logic rc_rise;
  logic sr_rise;

  link_sync #(.STAGES(SYNC_STAGES)) u_rclk (
    .clk   (clk),
    .reset (reset),
    .d     (RCLK),
    .rise  (rc_rise)
  );

  link_sync #(.STAGES(SYNC_STAGES)) u_srclk (
    .clk   (clk),
    .reset (reset),
    .d     (SRCLK),
    .rise  (sr_rise)
  );

  logic [SYNC_STAGES-1:0] dio_q;
  logic                   dio_d;

  // DIO gets the same depth plus one flop so it lines up with sr_rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dio_q <= '0;
      dio_d <= 1'b0;
    end else begin
      dio_q <= {dio_q[SYNC_STAGES-2:0], DIO};
      dio_d <= dio_q[SYNC_STAGES-1];
    end
  end

  logic [FRAME_BITS-1:0] shift_reg;
  logic [4:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shift_nx;
  logic [4:0]            cnt_nx;
  logic [7:0]            seg;
  logic [7:0]            sel;
  seg_dec_t              dec;
  logic                  len_bad;
  logic                  sel_one;

  // Shift first, so a coincident latch sees the newest bit.
  always_comb begin
    shift_nx = shift_reg;
    cnt_nx   = bit_cnt;
    if (sr_rise) begin
      shift_nx = {shift_reg[FRAME_BITS-2:0], dio_d};
      cnt_nx   = (bit_cnt == 5'd31) ? bit_cnt : bit_cnt + 5'd1;
    end
    seg     = shift_nx[FRAME_BITS-1 -: 8];
    sel     = shift_nx[7:0];
    dec     = hc595_decode(seg);
    len_bad = (cnt_nx != 5'(FRAME_BITS));
    sel_one = ($countones(~sel) == 1);
  end

  // Shift/count, latch on RCLK, then check and update the display buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg    <= '0;
      bit_cnt      <= '0;
      frame_data   <= '0;
      frame_valid  <= 1'b0;
      len_err      <= 1'b0;
      code_err     <= 1'b0;
      sel_err      <= 1'b0;
      disp_nibbles <= '0;
      blank_mask   <= '1;
      dp_mask      <= '0;
    end else begin
      frame_valid <= 1'b0;
      len_err     <= 1'b0;
      code_err    <= 1'b0;
      sel_err     <= 1'b0;
      shift_reg   <= shift_nx;
      bit_cnt     <= cnt_nx;
      if (rc_rise) begin
        bit_cnt     <= '0;
        frame_data  <= shift_nx;
        frame_valid <= 1'b1;
        if (len_bad) begin
          len_err <= 1'b1;
        end else if (sel == 8'hFF) begin
        end else if (!sel_one) begin
          sel_err <= 1'b1;
        end else if (!dec.known) begin
          code_err <= 1'b1;
        end else begin
          for (int i = 0; i < DIGITS; i++) begin
            if (!sel[i]) begin
              disp_nibbles[4*i +: 4] <= dec.nibble;
              blank_mask[i]          <= dec.blank;
              dp_mask[i]             <= ~seg[7];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hc595_frame_rx.sv
// tb_hc595_frame_rx: directed table-driven bench for the 595 link receiver.
// Link phases are 4 clk each; inputs change on the falling clk edge.
module tb_hc595_frame_rx;

  logic        clk;
  logic        reset;
  logic        RCLK;
  logic        SRCLK;
  logic        DIO;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic [31:0] disp_nibbles;
  logic [7:0]  blank_mask;
  logic [7:0]  dp_mask;
  logic        len_err;
  logic        code_err;
  logic        sel_err;

  int total = 0;
  int bad   = 0;

  hc595_frame_rx dut (
    .clk          (clk),
    .reset        (reset),
    .RCLK         (RCLK),
    .SRCLK        (SRCLK),
    .DIO          (DIO),
    .frame_data   (frame_data),
    .frame_valid  (frame_valid),
    .disp_nibbles (disp_nibbles),
    .blank_mask   (blank_mask),
    .dp_mask      (dp_mask),
    .len_err      (len_err),
    .code_err     (code_err),
    .sel_err      (sel_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    int          nbits;
    logic [15:0] frame;
    logic [31:0] nib;
    logic [7:0]  blank;
    logic [7:0]  dp;
    logic [2:0]  err;
  } vec_t;

  vec_t tv [9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic shift_bit(input logic b);
    @(negedge clk);
    DIO = b;
    repeat (4) @(negedge clk);
    SRCLK = 1'b1;
    repeat (4) @(negedge clk);
    SRCLK = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) shift_bit(w[i]);
  endtask

  task automatic wait_valid(input string nm);
    int lat;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (frame_valid) lat = k;
    end
    chk({nm, " latency"}, 32'(lat), 32'd4);
  endtask

  task automatic check_state(input string nm, input logic [15:0] fr,
                             input logic [31:0] nib, input logic [7:0] bl,
                             input logic [7:0] dp, input logic [2:0] err);
    chk({nm, " frame"}, 32'(frame_data), 32'(fr));
    chk({nm, " nib"}, disp_nibbles, nib);
    chk({nm, " blank"}, 32'(blank_mask), 32'(bl));
    chk({nm, " dp"}, 32'(dp_mask), 32'(dp));
    chk({nm, " err"}, 32'({len_err, sel_err, code_err}), 32'(err));
  endtask

  task automatic end_latch(input string nm);
    @(posedge clk);
    #1;
    chk({nm, " pulse1"}, 32'({frame_valid, len_err, sel_err, code_err}), 0);
    repeat (4) @(negedge clk);
    RCLK = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic latch(input string nm);
    @(negedge clk);
    RCLK = 1'b1;
    wait_valid(nm);
  endtask

  initial begin
    tv[0] = '{16'hC0FE, 16, 16'hC0FE, 32'h0000_0000, 8'hFE, 8'h00, 3'b000};
    tv[1] = '{16'h107F, 16, 16'h107F, 32'h9000_0000, 8'h7E, 8'h80, 3'b000};
    tv[2] = '{16'h1234, 15, 16'h9234, 32'h9000_0000, 8'h7E, 8'h80, 3'b100};
    tv[3] = '{16'hA4FC, 16, 16'hA4FC, 32'h9000_0000, 8'h7E, 8'h80, 3'b010};
    tv[4] = '{16'hABFE, 16, 16'hABFE, 32'h9000_0000, 8'h7E, 8'h80, 3'b001};
    tv[5] = '{16'hF9FF, 16, 16'hF9FF, 32'h9000_0000, 8'h7E, 8'h80, 3'b000};
    tv[6] = '{16'h7FFD, 16, 16'h7FFD, 32'h9000_0000, 8'h7E, 8'h82, 3'b000};
    tv[7] = '{16'h06EF, 16, 16'h06EF, 32'h900E_0000, 8'h6E, 8'h92, 3'b000};
    tv[8] = '{16'h88DF, 16, 16'h88DF, 32'h90AE_0000, 8'h4E, 8'h92, 3'b000};

    reset = 1'b1;
    RCLK  = 1'b0;
    SRCLK = 1'b0;
    DIO   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_state("reset", 16'h0000, 32'h0, 8'hFF, 8'h00, 3'b000);
    chk("reset valid", 32'(frame_valid), 0);

    for (int v = 0; v < 9; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      send_bits(tv[v].word, tv[v].nbits);
      latch(nm);
      check_state(nm, tv[v].frame, tv[v].nib, tv[v].blank, tv[v].dp,
                  tv[v].err);
      end_latch(nm);
    end

    send_bits(16'hF9FD, 8);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_state("midrst", 16'h0000, 32'h0, 8'hFF, 8'h00, 3'b000);
    send_bits(16'hF9FD, 16);
    latch("afterrst");
    check_state("afterrst", 16'hF9FD, 32'h0000_0010, 8'hFD, 8'h00, 3'b000);
    end_latch("afterrst");

    send_bits(16'h8EFB >> 1, 15);
    @(negedge clk);
    DIO = 1'b1;
    repeat (4) @(negedge clk);
    SRCLK = 1'b1;
    RCLK  = 1'b1;
    wait_valid("simul");
    check_state("simul", 16'h8EFB, 32'h0000_0F10, 8'hF9, 8'h00, 3'b000);
    end_latch("simul");
    SRCLK = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hc595_frame_rx.md
# hc595_frame_rx

Serial receiver for the three-wire 74HC595 display link (RCLK, SRCLK, DIO) that the hex display driver transmits. It over-samples the link in the system clock domain, shifts in each 16-bit frame, latches it on RCLK, and decodes the segment/select pair back into a per-digit value buffer. It is used as the on-chip loopback checker for the display path and as the front end of a remote display board fed by a second FPGA.

## Interface
- FRAME_BITS, 16, bits per frame; the first 8 shifted are segment, the last 8 are select.
- DIGITS, 8, number of digit positions tracked.
- SYNC_STAGES, 2, synchroniser depth on each link input (≥2).
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high; clears all state.
- RCLK  in  1  link latch clock, asynchronous to clk.
- SRCLK  in  1  link shift clock, asynchronous to clk.
- DIO  in  1  link serial data, sampled on SRCLK rising.
- frame_data  out  16  last latched frame; [15:8]=seg, [7:0]=sel.
- frame_valid  out  1  one-cycle pulse per accepted RCLK rising edge.
- disp_nibbles  out  4*DIGITS  decoded hex value per digit; digit i is at [4i+3:4i].
- blank_mask  out  DIGITS  1 = digit i shows blank (seg 0xFF).
- dp_mask  out  DIGITS  1 = decimal point of digit i is lit.
- len_err  out  1  one-cycle pulse: RCLK arrived with bit count ≠ FRAME_BITS.
- code_err  out  1  one-cycle pulse: unknown segment pattern.
- sel_err  out  1  one-cycle pulse: select has more than one active bit.

## Operation
- RCLK, SRCLK and DIO each pass through SYNC_STAGES flops, plus one history flop for edge detection. DIO uses the same depth, so it stays aligned with SRCLK.
- SRCLK rising edge (synchronised): shift_reg <= {shift_reg[14:0], DIO_sync}. bit_cnt increments and saturates at 31.
- RCLK rising edge (synchronised):
  - frame_data <= shift_reg, and frame_valid pulses.
  - bit_cnt clears to 0. shift_reg is retained, matching 595 behaviour.
- Frame checks, in priority order; any failure leaves disp_nibbles, blank_mask and dp_mask unchanged:
  - bit_cnt ≠ FRAME_BITS: len_err pulses.
  - sel = 0xFF: no digit active; no error and no update.
  - sel not one-hot-low: sel_err pulses.
  - seg not in the decode table: code_err pulses.
- Segment coding is active-low {dp,g,f,e,d,c,b,a}. The decode looks up seg|0x80 (dp stripped).
  - 0-9: C0 F9 A4 B0 99 92 82 F8 80 90.
  - A-F: 88 83 C6 A1 86 8E.
  - FF: blank; the nibble is written as 0 and blank_mask[i] is set.
- Valid frame with sel bit i = 0:
  - disp_nibbles[i] <= decoded value.
  - blank_mask[i] <= (seg|0x80 == 0xFF).
  - dp_mask[i] <= ~seg[7].
- Simultaneous SRCLK and RCLK rising edges in the same synchronised cycle: the shift and the bit count increment happen first, and the latch includes that bit.
- Reset values:
  - frame_data 0, all error pulses 0, frame_valid 0.
  - disp_nibbles 0, blank_mask all 1, dp_mask 0.
  - shift_reg 0, bit_cnt 0, all sync flops 0.

## Timing
- Link constraint: each SRCLK/RCLK high and low phase lasts ≥ 3 clk periods, and DIO is stable ≥ 3 clk periods around each SRCLK rising edge. Faster links are unsupported.
- Let edge N be the first clk edge that samples RCLK high. At edge N+SYNC_STAGES+1 (N+3 by default), frame_valid, frame_data, the error pulses and the display buffers all update together.
- Shift latency is the same: shift_reg reflects a bit 3 clk after SRCLK is first sampled high.
- Error pulses are mutually exclusive and last exactly one cycle, coincident with frame_valid.
- Reset asserted mid-frame discards partial bits. The first frame after release must be complete to be accepted.

## Structure
- Package hc595_pkg:
  - FRAME_BITS default.
  - Active-low 7-segment code constants for 0-F and blank.
  - A decode function returning {known, blank, nibble}.
- Sub-module link_sync: parameterised SYNC_STAGES synchroniser plus rising-edge detector. It is instantiated for RCLK and SRCLK; DIO uses the plain synchroniser path.
- The top level holds the shift register, bit counter, frame checks and display buffers.

## Test plan
- Shift 0xC0FE, then RCLK: frame_data=0xC0FE, frame_valid pulses at N+3, disp_nibbles[3:0]=0, blank_mask[0]=0, no errors.
- Shift 0x107F (9 with dp, digit 7): disp_nibbles[31:28]=9, dp_mask[7]=1, other digits unchanged.
- Shift 15 bits, then RCLK: len_err pulses, frame_data updates, display buffers unchanged.
- Shift 0xA4FC (two selects active): sel_err. Shift 0xABFE: code_err. In both cases the buffers are unchanged.
- Assert reset after 8 bits of a frame, then send full frame 0xF9FD: digit 1 decodes to 1, and blank_mask = 0xFD.
- On the 16th bit of 0x8EFB, SRCLK and RCLK rise in the same clk cycle: frame accepted with full 16 bits, digit 2 = 0xF, no len_err.
